puf_soc_mux_scan: RTL and testbench

Parametrised, sequenced successor to the PUF SoC N:1 response mux.
- Selects one of MUX_SZ response channels, each N_BIT wide, from a flattened input bus.
- Waits a programmable settle time, then registers the selected value and presents it on a valid/ready handshake.
- Operates in single-channel mode or in sweep mode over an inclusive channel range.
- Sits between the PUF response array and the response collector/FIFO.

---
 rtl/puf_soc_mux_scan.sv | 157 +++++++++++++++
 tb/tb_puf_soc_mux_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_soc_mux_scan.sv
// puf_soc_mux_scan: sequenced N:1 response mux for the PUF array.
// The block selects one channel and waits for it to settle. It then captures the
// channel and hands it downstream over a valid/ready handshake. It works on a
// single channel or sweeps an ascending inclusive channel range.
module puf_soc_mux_scan #(
   parameter  int N_BIT      = 1,
   parameter  int MUX_SZ     = 16,
   parameter  int SETTLE_CYC = 2,
   localparam int SEL_W      = $clog2(MUX_SZ)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [MUX_SZ*N_BIT-1:0] i_data,
   input  logic                    i_start,
   input  logic                    i_mode,
   input  logic [SEL_W-1:0]        i_sel,
   input  logic [SEL_W-1:0]        i_last,
   input  logic                    i_ready,
   output logic [N_BIT-1:0]        o_data,
   output logic [SEL_W-1:0]        o_sel,
   output logic                    o_valid,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err
);

   // Settle counter needs at least one bit even when SETTLE_CYC == 1.
   localparam int                CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
   // One extra bit so that MUX_SZ itself is representable for range checks.
   localparam logic [SEL_W:0]    MUX_LIM  = (SEL_W+1)'(MUX_SZ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   cur_q, cur_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_BIT-1:0]   data_q, data_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               cfg_bad;

   // Unflatten the input bus into per-channel words.
   logic [N_BIT-1:0]   chan [MUX_SZ];
   for (genvar k = 0; k < MUX_SZ; k++) begin : g_chan
      assign chan[k] = i_data[k*N_BIT +: N_BIT];
   end

   // Start configuration check: the index must be in range, and the sweep must be ascending and in range.
   always_comb begin
      cfg_bad = 1'b0;
      if ({1'b0, i_sel} >= MUX_LIM)
         cfg_bad = 1'b1;
      if (i_mode && (({1'b0, i_last} >= MUX_LIM) || (i_last < i_sel)))
         cfg_bad = 1'b1;
   end

   // Next-state and registered-output logic. The done and err pulses default low every cycle.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  cur_d   = i_sel;
                  last_d  = i_mode ? i_last : i_sel;
                  cnt_d   = CNT_LOAD;
                  busy_d  = 1'b1;
                  state_d = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               data_d  = chan[cur_q];
               sel_d   = cur_q;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Captured data is frozen here, so i_data may change freely.
            if (i_ready) begin
               valid_d = 1'b0;
               if (cur_q != last_q) begin
                  cur_d   = cur_q + SEL_W'(1);
                  cnt_d   = CNT_LOAD;
                  state_d = SETTLE;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset that clears everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign o_data  = data_q;
   assign o_sel   = sel_q;
   assign o_valid = valid_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_puf_soc_mux_scan.sv
// Directed bench for puf_soc_mux_scan with N_BIT=1, MUX_SZ=16, SETTLE_CYC=2.
module tb_puf_soc_mux_scan;

   logic        i_clk;
   logic        i_rst;
   logic [15:0] i_data;
   logic        i_start;
   logic        i_mode;
   logic [3:0]  i_sel;
   logic [3:0]  i_last;
   logic        i_ready;
   logic [0:0]  o_data;
   logic [3:0]  o_sel;
   logic        o_valid;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   int pass_cnt = 0;
   int total    = 0;

   logic [15:0] pat = 16'hA5C3;
   logic [3:0]  k4;

   puf_soc_mux_scan #(.N_BIT(1), .MUX_SZ(16), .SETTLE_CYC(2)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_data  (i_data),
      .i_start (i_start),
      .i_mode  (i_mode),
      .i_sel   (i_sel),
      .i_last  (i_last),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_sel   (o_sel),
      .o_valid (o_valid),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_err   (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance one rising edge and settle 1 ns past it before driving or sampling.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   initial begin
      int n;
      bit hit;
      // ---- reset with start held high
      i_rst = 1'b1; i_data = pat; i_start = 1'b1; i_mode = 1'b0;
      i_sel = 4'd6; i_last = 4'd0; i_ready = 1'b1;
      repeat (3) tick();
      chk1("rst_data", o_data[0], 1'b0);
      chk4("rst_sel", o_sel, 4'd0);
      chk1("rst_valid", o_valid, 1'b0);
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_done", o_done, 1'b0);
      chk1("rst_err", o_err, 1'b0);
      i_rst = 1'b0; i_start = 1'b0;
      tick();
      chk1("post_rst_busy", o_busy, 1'b0);

      // ---- single channel 6
      i_start = 1'b1; i_mode = 1'b0; i_sel = 4'd6;
      tick();
      i_start = 1'b0;
      chk1("single_busy", o_busy, 1'b1);
      chk1("single_v0", o_valid, 1'b0);
      tick();
      chk1("single_v1", o_valid, 1'b0);
      tick();
      chk1("single_valid", o_valid, 1'b1);
      chk1("single_data", o_data[0], 1'b1);
      chk4("single_sel", o_sel, 4'd6);
      tick();
      chk1("single_done", o_done, 1'b1);
      chk1("single_busy_off", o_busy, 1'b0);
      chk1("single_valid_off", o_valid, 1'b0);
      chk4("single_sel_hold", o_sel, 4'd6);
      tick();
      chk1("single_done_pulse", o_done, 1'b0);

      // ---- full sweep 0..15; a start request with a bad range is injected mid-sweep
      i_start = 1'b1; i_mode = 1'b1; i_sel = 4'd0; i_last = 4'd15;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         n = (k == 0) ? 2 : 3;
         for (int j = 0; j < n; j++) begin
            tick();
            if (j < n - 1) chk1("sweep_gap", o_valid, 1'b0);
            if (k == 6 && j == 0) begin
               chk1("busy_start_err", o_err, 1'b0);
               i_start = 1'b0;
            end
         end
         k4 = 4'(k);
         chk1("sweep_valid", o_valid, 1'b1);
         chk4("sweep_sel", o_sel, k4);
         chk1("sweep_data", o_data[0], pat[k]);
         chk1("sweep_nodone", o_done, 1'b0);
         if (k == 5) begin
            i_start = 1'b1; i_sel = 4'd9; i_last = 4'd2;
         end
      end
      tick();
      chk1("sweep_done", o_done, 1'b1);
      chk1("sweep_busy_off", o_busy, 1'b0);
      tick();
      chk1("sweep_done_pulse", o_done, 1'b0);
      chk1("sweep_no_err", o_err, 1'b0);

      // ---- backpressure: sweep 3..5 with ready low on channel 4 while i_data changes
      i_ready = 1'b0; i_start = 1'b1; i_mode = 1'b1; i_sel = 4'd3; i_last = 4'd5;
      tick();
      i_start = 1'b0;
      repeat (2) tick();
      chk1("bp_v3", o_valid, 1'b1);
      chk4("bp_sel3", o_sel, 4'd3);
      chk1("bp_data3", o_data[0], 1'b0);
      tick();
      chk4("bp_stall3", o_sel, 4'd3);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk1("bp_v_drop", o_valid, 1'b0);
      repeat (2) tick();
      chk1("bp_v4", o_valid, 1'b1);
      chk4("bp_sel4", o_sel, 4'd4);
      chk1("bp_data4", o_data[0], 1'b0);
      i_data = 16'hFFFF;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk1("bp_hold_valid", o_valid, 1'b1);
         chk4("bp_hold_sel", o_sel, 4'd4);
         chk1("bp_hold_data", o_data[0], 1'b0);
      end
      i_ready = 1'b1;
      tick();
      chk1("bp_hs_valid", o_valid, 1'b0);
      chk1("bp_hs_busy", o_busy, 1'b1);
      repeat (2) tick();
      chk1("bp_v5", o_valid, 1'b1);
      chk4("bp_sel5", o_sel, 4'd5);
      chk1("bp_data5", o_data[0], 1'b1);
      tick();
      chk1("bp_done", o_done, 1'b1);
      i_data = pat;

      // ---- illegal sweep range
      i_start = 1'b1; i_mode = 1'b1; i_sel = 4'd4; i_last = 4'd2;
      tick();
      i_start = 1'b0;
      chk1("err_pulse", o_err, 1'b1);
      chk1("err_busy", o_busy, 1'b0);
      tick();
      chk1("err_pulse_end", o_err, 1'b0);
      chk1("err_busy2", o_busy, 1'b0);
      chk1("err_valid", o_valid, 1'b0);

      // ---- reset mid-sweep when channel 7 is presented
      i_start = 1'b1; i_mode = 1'b1; i_sel = 4'd0; i_last = 4'd15;
      tick();
      i_start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         if (o_valid && o_sel == 4'd7) hit = 1'b1;
      end
      chk1("mid_reach_sel7", hit, 1'b1);
      chk1("mid_data7", o_data[0], 1'b1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk1("mid_rst_data", o_data[0], 1'b0);
      chk4("mid_rst_sel", o_sel, 4'd0);
      chk1("mid_rst_valid", o_valid, 1'b0);
      chk1("mid_rst_busy", o_busy, 1'b0);
      chk1("mid_rst_done", o_done, 1'b0);
      chk1("mid_rst_err", o_err, 1'b0);
      i_start = 1'b1; i_mode = 1'b0; i_sel = 4'd0;
      tick();
      i_start = 1'b0;
      repeat (2) tick();
      chk1("restart_valid", o_valid, 1'b1);
      chk1("restart_data", o_data[0], 1'b1);
      chk4("restart_sel", o_sel, 4'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
